counter: RTL and testbench



---
 rtl/counter_pkg.sv | 8 +
 rtl/counter.sv | 33 +++
 tb/tb_counter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the CPU timing sequencer.
//   CNT_W : default width of the T-state counter, for blocks that decode count.
package counter_pkg;

    localparam int unsigned CNT_W = 2;

endpackage : counter_pkg

// File: rtl/counter.sv
module counter
    import counter_pkg::*;
#(
    parameter int unsigned N   = CNT_W,
    parameter int unsigned MOD = 2 ** N
) (
    input  logic         clk,
    input  logic         clear,
    output logic [N-1:0] count
);

    // Terminal value, truncated to the count width so that MOD == 2**N
    // still compares correctly.
    localparam logic [N-1:0] TOP = N'(MOD - 1);

    logic [N-1:0] count_nxt;

    always_comb begin
        count_nxt = count + N'(1);
        if (count == TOP) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter
//   Self-checking bench for counter. Three instances (N=2/MOD=4,
//   N=3/MOD=5, N=4/MOD=16) share clk and clear. Expected values are
//   produced by a small modulo model and queued when each edge is driven,
//   then popped and compared one time unit after the edge.
module tb_counter;

    logic       clk;
    logic       clear;
    logic [1:0] count2;
    logic [2:0] count5;
    logic [3:0] count16;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [31:0] c2;
        logic [31:0] c5;
        logic [31:0] c16;
    } exp_t;

    exp_t sbq[$];

    int unsigned m2  = 0;
    int unsigned m5  = 0;
    int unsigned m16 = 0;

    counter #(.N(2), .MOD(4)) u_c2 (
        .clk   (clk),
        .clear (clear),
        .count (count2)
    );

    counter #(.N(3), .MOD(5)) u_c5 (
        .clk   (clk),
        .clear (clear),
        .count (count5)
    );

    counter #(.N(4), .MOD(16)) u_c16 (
        .clk   (clk),
        .clear (clear),
        .count (count16)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int unsigned nxt(input int unsigned v, input int unsigned m);
        return (v + 1 == m) ? 0 : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_c2"},  {30'd0, count2},  m2);
        chk({tag, "_c5"},  {29'd0, count5},  m5);
        chk({tag, "_c16"}, {28'd0, count16}, m16);
    endtask

    // Drive one rising edge: queue the model's prediction, then compare.
    task automatic step(input string tag);
        exp_t e;
        m2  = clear ? 0 : nxt(m2, 4);
        m5  = clear ? 0 : nxt(m5, 5);
        m16 = clear ? 0 : nxt(m16, 16);
        e.c2  = m2;
        e.c5  = m5;
        e.c16 = m16;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "_c2"},  {30'd0, count2},  e.c2);
        chk({tag, "_c5"},  {29'd0, count5},  e.c5);
        chk({tag, "_c16"}, {28'd0, count16}, e.c16);
        checks++;
        assert (count5 < 3'd5) else begin
            errors++;
            $error("FAIL %s_c5_range: observed=%0d expected=<5", tag, count5);
        end
    endtask

    initial begin
        // Reset hold: clear high from t=0 to t=40 across edges at 10 and 30.
        clear = 1'b1;
        #5;
        chk_all("reset_async");
        step("reset_hold0");
        step("reset_hold1");

        // Release at t=40; edges at 50,70,90,110 give 1,2,3,0 on N=2.
        #9;
        clear = 1'b0;
        step("release1");
        step("release2");
        step("release3");
        step("release_wrap");

        // Bring N=2 counter to 2, then clear between edges.
        step("pre_mid1");
        step("pre_mid2");
        chk("mid_at2", {30'd0, count2}, 32'd2);
        #5;
        clear = 1'b1;
        m2  = 0;
        m5  = 0;
        m16 = 0;
        #1;
        chk_all("mid_clear");
        #3;
        clear = 1'b0;
        step("mid_resume");

        // Long run of 16 edges.
        for (int i = 0; i < 16; i++) begin
            step("long");
        end

        // Width check: fresh clear, then 20 edges -> N=4 counter reads 4.
        #5;
        clear = 1'b1;
        m2  = 0;
        m5  = 0;
        m16 = 0;
        #1;
        chk_all("width_clear");
        #3;
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step("width");
        end
        chk("width_c16_final", {28'd0, count16}, 32'd4);
        chk("width_c2_final",  {30'd0, count2},  32'd0);
        chk("width_c5_final",  {29'd0, count5},  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter
